// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage binary32 rounding and packing pipeline.
// Stage 1 normalises/denormalises, stage 2 rounds, packs and flags.
module fp_rnd_pipe #(
    parameter bit SUBNORMAL_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sig,
    input  logic [9:0]  in_expo,
    input  logic [24:0] in_mant,
    input  logic [2:0]  in_grs,
    input  logic [2:0]  in_rm,
    input  logic        in_snan,
    input  logic        in_qnan,
    input  logic        in_dbz,
    input  logic        in_inf,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);

    typedef struct packed {
        logic        sig;
        logic [9:0]  expo;
        logic [23:0] mant;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic        tiny;
        logic        flush;
        logic        inexact;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
    } s1_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        s1_valid;
    logic        s2_valid;
    logic        s1_adv;
    logic        s2_adv;
    s1_t         r1;
    s1_t         n1;

    // stage 1 working signals
    logic signed [9:0]  s1_e;
    logic [23:0]        s1_m;
    logic [2:0]         s1_grs;
    logic signed [10:0] sh_full;
    logic [4:0]         sh;
    logic [25:0]        dn_vec;
    logic [25:0]        dn_shf;
    logic [25:0]        dn_mask;
    logic               dn_lost;
    logic               s1_tiny;
    logic               s1_flush;

    // stage 2 working signals
    logic               g;
    logic               lsb;
    logic               rm_rtz;
    logic               rm_rdn;
    logic               rm_rup;
    logic               rm_rmm;
    logic               inc;
    logic [24:0]        sum;
    logic signed [9:0]  e2;
    logic [22:0]        frac;
    logic               ovf;
    logic               max_fin;
    logic [31:0]        n2_res;
    logic [4:0]         n2_flg;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // normalise carry, then denormalise or flag flush for tiny exponents
    always_comb begin
        s1_e     = in_expo;
        s1_m     = in_mant[23:0];
        s1_grs   = in_grs;
        s1_tiny  = 1'b0;
        s1_flush = 1'b0;
        sh_full  = '0;
        sh       = '0;
        dn_vec   = '0;
        dn_shf   = '0;
        dn_mask  = '0;
        dn_lost  = 1'b0;
        if (in_mant[24]) begin
            s1_m   = in_mant[24:1];
            s1_grs = {in_mant[0], in_grs[2], in_grs[1] | in_grs[0]};
            s1_e   = s1_e + 10'sd1;
        end
        if (s1_e <= 10'sd0) begin
            if (SUBNORMAL_EN) begin
                // shift amount 1-expo, saturated: past 26 every bit is lost
                sh_full = 11'sd1 - $signed({s1_e[9], s1_e});
                sh      = (sh_full > 11'sd26) ? 5'd26 : sh_full[4:0];
                dn_vec  = {s1_m, s1_grs[2:1]};
                dn_mask = ~({26{1'b1}} << sh);
                dn_lost = |(dn_vec & dn_mask);
                dn_shf  = dn_vec >> sh;
                s1_m    = dn_shf[25:2];
                s1_grs  = {dn_shf[1:0], s1_grs[0] | dn_lost};
                s1_e    = '0;
                s1_tiny = 1'b1;
            end else begin
                s1_flush = 1'b1;
            end
        end
        n1.sig     = in_sig;
        n1.expo    = s1_e;
        n1.mant    = s1_m;
        n1.grs     = s1_grs;
        n1.rm      = in_rm;
        n1.tiny    = s1_tiny;
        n1.flush   = s1_flush;
        n1.inexact = |s1_grs;
        n1.snan    = in_snan;
        n1.qnan    = in_qnan;
        n1.dbz     = in_dbz;
        n1.inf     = in_inf;
        n1.zero    = in_zero;
    end

    // round, detect overflow and select the special-case result
    always_comb begin
        g       = r1.grs[2];
        lsb     = r1.mant[0];
        rm_rtz  = (r1.rm == 3'd1);
        rm_rdn  = (r1.rm == 3'd2);
        rm_rup  = (r1.rm == 3'd3);
        rm_rmm  = (r1.rm == 3'd4);
        inc     = 1'b0;
        unique case (1'b1)
            rm_rtz:  inc = 1'b0;
            rm_rdn:  inc = r1.sig & r1.inexact;
            rm_rup:  inc = ~r1.sig & r1.inexact;
            rm_rmm:  inc = g;
            default: inc = g & (lsb | r1.grs[1] | r1.grs[0]);
        endcase
        sum  = {1'b0, r1.mant} + {24'd0, inc};
        e2   = r1.expo;
        frac = sum[22:0];
        if (sum[24]) begin
            e2   = r1.expo + 10'sd1;
            frac = '0;
        end else if (r1.tiny && sum[23]) begin
            e2 = 10'sd1;
        end
        ovf     = (e2 >= 10'sd255);
        max_fin = rm_rtz | (rm_rdn & ~r1.sig) | (rm_rup & r1.sig);
        n2_res  = {r1.sig, e2[7:0], frac};
        n2_flg  = {3'b000, r1.tiny & r1.inexact, r1.inexact};
        if (ovf) begin
            n2_res = max_fin ? {r1.sig, 31'h7F7F_FFFF}
                             : {r1.sig, 8'hFF, 23'd0};
            n2_flg = 5'b00101;
        end
        if (r1.snan) begin
            n2_res = QNAN;
            n2_flg = 5'b10000;
        end else if (r1.qnan) begin
            n2_res = QNAN;
            n2_flg = 5'b00000;
        end else if (r1.dbz) begin
            n2_res = {r1.sig, 8'hFF, 23'd0};
            n2_flg = 5'b01000;
        end else if (r1.inf) begin
            n2_res = {r1.sig, 8'hFF, 23'd0};
            n2_flg = 5'b00000;
        end else if (r1.zero) begin
            n2_res = {r1.sig, 31'd0};
            n2_flg = 5'b00000;
        end else if (r1.flush) begin
            n2_res = {r1.sig, 31'd0};
            n2_flg = 5'b00011;
        end
    end

    // stage 1 register: loads only when a record is accepted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            r1       <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                r1 <= n1;
            end
        end
    end

    // stage 2 register: output held while the consumer stalls
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (clear) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= n2_res;
                out_flags  <= n2_flg;
            end
        end
    end

endmodule
